// File: rtl/keypad_pkg.sv
// Shared constants, key map and state encodings for the front-panel keypad.
// Key codes 0-9 are digits, 10 is start and 11 is cancel.
package keypad_pkg;

    localparam logic [3:0] KEY_START  = 4'd10;
    localparam logic [3:0] KEY_CANCEL = 4'd11;
    localparam int         NUM_KEYS   = 12;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } cand_t;

    function automatic logic [3:0] key_map(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [3:0] code;
        code = 4'd0;
        if (row == 2'd3) begin
            unique case (col)
                2'd0:    code = KEY_CANCEL;
                2'd1:    code = 4'd0;
                default: code = KEY_START;
            endcase
        end else begin
            code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_core.sv
// Column scan, row synchronizer and per-scan snapshot of pressed keys.
// Snapshot bit (col*4 + row) is high when that key reads as pressed.
module keypad_scan_core #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [2:0]  col_n,
    output logic [11:0] snapshot,
    output logic        scan_done
);

    localparam int            DW      = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [DW-1:0] r_div;
    logic [1:0]    r_col;
    logic [2:0]    r_col_n;
    logic [11:0]   r_snap;

    logic          w_sample;
    logic [1:0]    w_col_nxt;
    logic [3:0]    w_base;

    assign w_sample  = (r_div == DIV_MAX);
    assign w_col_nxt = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
    assign w_base    = {r_col, 2'b00};
    assign scan_done = w_sample && (r_col == 2'd2);
    assign col_n     = r_col_n;

    // The live column-2 sample is merged in so the full scan is visible at the boundary.
    always_comb begin
        snapshot = r_snap;
        if (w_sample) begin
            snapshot[w_base +: 4] = ~r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_div   <= '0;
            r_col   <= 2'd0;
            r_col_n <= 3'b110;
            r_snap  <= '0;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
            if (w_sample) begin
                r_div               <= '0;
                r_col               <= w_col_nxt;
                r_col_n             <= ~(3'b001 << w_col_nxt);
                r_snap[w_base +: 4] <= ~r_sync2;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad scanner top: classifies each full scan, debounces press/release
// and emits a single one-hot pulse per accepted key press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          row_n,
    output logic [2:0]          col_n,
    output logic [NUM_KEYS-1:0] t,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic                key_held
);

    localparam int            CW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB_N = CW'(DEBOUNCE_SCANS);

    logic [11:0]         w_snap;
    logic                w_scan_done;
    logic [3:0]          w_nkeys;
    logic [3:0]          w_code;
    cand_t               w_class;
    logic [CW-1:0]       w_cnt_inc;
    logic [NUM_KEYS-1:0] w_onehot;

    state_t              r_state;
    logic [3:0]          r_cand;
    logic [CW-1:0]       r_cnt;
    logic [NUM_KEYS-1:0] r_t;
    logic                r_kv;
    logic [3:0]          r_code;
    logic                r_held;

    keypad_scan_core #(
        .SCAN_DIV (SCAN_DIV)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .snapshot  (w_snap),
        .scan_done (w_scan_done)
    );

    always_comb begin
        w_nkeys = 4'd0;
        w_code  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (w_snap[i]) begin
                w_nkeys = w_nkeys + 4'd1;
                w_code  = key_map(2'(i % 4), 2'(i / 4));
            end
        end
        if (w_nkeys == 4'd0) begin
            w_class = NONE;
        end else if (w_nkeys == 4'd1) begin
            w_class = KEY;
        end else begin
            w_class = MULTI;
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_onehot  = NUM_KEYS'(1) << w_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cand  <= 4'd0;
            r_cnt   <= '0;
            r_t     <= '0;
            r_kv    <= 1'b0;
            r_code  <= 4'd0;
            r_held  <= 1'b0;
        end else begin
            r_t  <= '0;
            r_kv <= 1'b0;
            if (w_scan_done) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_class == KEY) begin
                            r_cand <= w_code;
                            r_cnt  <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                r_t     <= w_onehot;
                                r_kv    <= 1'b1;
                                r_code  <= w_code;
                                r_held  <= 1'b1;
                                r_state <= HELD;
                            end else begin
                                r_state <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (w_class != KEY) begin
                            r_state <= IDLE;
                        end else if (w_code != r_cand) begin
                            r_cand <= w_code;
                            r_cnt  <= CW'(1);
                        end else if (w_cnt_inc == DB_N) begin
                            r_t     <= w_onehot;
                            r_kv    <= 1'b1;
                            r_code  <= w_code;
                            r_held  <= 1'b1;
                            r_state <= HELD;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    HELD: begin
                        if (w_class == NONE) begin
                            r_cnt <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                r_held  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_state <= REL_DB;
                            end
                        end
                    end
                    REL_DB: begin
                        if (w_class != NONE) begin
                            r_state <= HELD;
                        end else if (w_cnt_inc == DB_N) begin
                            r_held  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign t         = r_t;
    assign key_valid = r_kv;
    assign key_code  = r_code;
    assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 keypad model.
// Each table step holds a key set for whole scans, then checks pulses and status.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [2:0]  col_n;
    logic [11:0] t;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;

    logic [11:0] keys;
    int          n_pass   = 0;
    int          n_total  = 0;
    int          cyc      = 0;
    int          pulses   = 0;
    logic [11:0] last_t   = '0;
    int          last_cyc = 0;

    typedef struct {
        logic [11:0] keys;
        int          scans;
        int          pulses;
        logic [11:0] last_t;
        logic [3:0]  code;
        logic        held;
        int          lat;
    } step_t;

    step_t steps[17];

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .t         (t),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int code_of(input int r, input int c);
        int m;
        case (r)
            0: m = c + 1;
            1: m = c + 4;
            2: m = c + 7;
            default: m = (c == 0) ? 11 : (c == 1) ? 0 : 10;
        endcase
        return m;
    endfunction

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!col_n[c] && keys[code_of(r, c)]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (t != 0) begin
            pulses++;
            last_t   = t;
            last_cyc = cyc;
        end
        check("pulse_shape",
              {31'd0, (key_valid == (t != 0)) && $onehot0(t)}, 32'd1);
    end

    initial begin
        logic [2:0] col_seq [3];
        int         p0;
        int         start;

        col_seq[0] = 3'b101;
        col_seq[1] = 3'b011;
        col_seq[2] = 3'b110;

        steps[0]  = '{12'h020, 5, 1, 12'h020, 4'd5,  1'b1, 24};
        steps[1]  = '{12'h000, 2, 0, 12'h020, 4'd5,  1'b0, 0};
        steps[2]  = '{12'h400, 1, 0, 12'h020, 4'd5,  1'b0, 0};
        steps[3]  = '{12'h000, 1, 0, 12'h020, 4'd5,  1'b0, 0};
        steps[4]  = '{12'h400, 3, 1, 12'h400, 4'd10, 1'b1, 24};
        steps[5]  = '{12'h000, 2, 0, 12'h400, 4'd10, 1'b0, 0};
        steps[6]  = '{12'h006, 4, 0, 12'h400, 4'd10, 1'b0, 0};
        steps[7]  = '{12'h002, 3, 1, 12'h002, 4'd1,  1'b1, 24};
        steps[8]  = '{12'h000, 2, 0, 12'h002, 4'd1,  1'b0, 0};
        steps[9]  = '{12'h001, 3, 1, 12'h001, 4'd0,  1'b1, 24};
        steps[10] = '{12'h080, 3, 0, 12'h001, 4'd0,  1'b1, 0};
        steps[11] = '{12'h000, 2, 0, 12'h001, 4'd0,  1'b0, 0};
        steps[12] = '{12'h080, 3, 1, 12'h080, 4'd7,  1'b1, 24};
        steps[13] = '{12'h000, 2, 0, 12'h080, 4'd7,  1'b0, 0};
        steps[14] = '{12'h008, 1, 0, 12'h080, 4'd7,  1'b0, 0};
        steps[15] = '{12'h040, 2, 1, 12'h040, 4'd6,  1'b1, 24};
        steps[16] = '{12'h000, 2, 0, 12'h040, 4'd6,  1'b0, 0};

        rst  = 1'b1;
        keys = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_col_n", 32'(col_n), 32'(3'b110));
        check("rst_t", 32'(t), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            #1;
            check("col_cycle", 32'(col_n), 32'(col_seq[k]));
        end

        for (int s = 0; s < 17; s++) begin
            keys  = steps[s].keys;
            p0    = pulses;
            start = cyc;
            repeat (12 * steps[s].scans) @(negedge clk);
            #1;
            check($sformatf("step%0d_pulses", s), 32'(pulses - p0),
                  32'(steps[s].pulses));
            check($sformatf("step%0d_last_t", s), 32'(last_t),
                  32'(steps[s].last_t));
            check($sformatf("step%0d_code", s), 32'(key_code),
                  32'(steps[s].code));
            check($sformatf("step%0d_held", s), 32'(key_held),
                  32'(steps[s].held));
            if (steps[s].lat != 0) begin
                check($sformatf("step%0d_latency", s), 32'(last_cyc - start),
                      32'(steps[s].lat));
            end
        end

        keys = 12'h800;
        p0   = pulses;
        repeat (36) @(negedge clk);
        #1;
        check("cancel_pulses", 32'(pulses - p0), 32'd1);
        check("cancel_last_t", 32'(last_t), 32'h800);
        check("cancel_held", 32'(key_held), 32'd1);

        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_col_n", 32'(col_n), 32'(3'b110));
        check("midrst_t", 32'(t), 32'd0);
        check("midrst_valid", 32'(key_valid), 32'd0);
        check("midrst_code", 32'(key_code), 32'd0);
        check("midrst_held", 32'(key_held), 32'd0);
        rst = 1'b0;

        p0    = pulses;
        start = cyc;
        repeat (36) @(negedge clk);
        #1;
        check("rerst_pulses", 32'(pulses - p0), 32'd1);
        check("rerst_last_t", 32'(last_t), 32'h800);
        check("rerst_code", 32'(key_code), 32'd11);
        check("rerst_held", 32'(key_held), 32'd1);
        check("rerst_latency", 32'(last_cyc - start), 32'd24);

        keys = '0;
        repeat (24) @(negedge clk);
        #1;
        check("final_held", 32'(key_held), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
